pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Drives the enables and flushes of the PC and all inter-stage registers: start/stop with orderly drain, load-use stall with bubble insertion, and squash of younger instructions when a branch/jump redirects in MEM.
- Sits beside the control unit inside the CPU top; replaces the raw global enable on pipeline registers.
- Exports stall/flush performance counters.

Parameters:
- FETCH_LAT, 1, cycles of instruction SRAM read latency after a PC redirect (extra IF/ID flush cycles, 0..3).
- DRAIN_CYCLES, 4, cycles needed to retire in-flight instructions on stop (1..15).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request (level).
- id_rs  in  5  rs field of instruction in ID (IF/ID [25:21]).
- id_rt  in  5  rt field of instruction in ID (IF/ID [20:16]).
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq).
- ex_mem_read  in  1  instruction in EX is a load (ID/EX mem_read).
- ex_rt  in  5  destination rt of instruction in EX.
- mem_redirect  in  1  taken branch or jump in MEM: (branch&zero)|jump, EX/MEM copies.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  zero control bits of ID/EX (bubble).
- ex_mem_flush  out  1  zero control bits of EX/MEM.
- busy  out  1  state != IDLE.
- state  out  3  current FSM state.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  redirect events, saturating.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; all enables and flushes 0; busy=0; both counters 0. Reset overrides any state, including mid-drain or mid-flush.
- All outputs except counters/state are combinational from state, down-counter and inputs. State and counters are registered.
- States: IDLE=0, RUN=1, FLUSH=2, DRAIN=3.
- IDLE: all enables 0, flushes 0. enable=1 -> RUN next cycle.
- RUN, no event: pc_en=if_id_en=pipe_en=1.
- Load-use hazard: hz = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN with hz and no redirect:
  - pc_en=0, if_id_en=0, id_ex_flush=1, pipe_en=1; state stays RUN.
  - stall_count++.
  - Exactly 1 bubble per load-use pair.
- RUN with mem_redirect (priority over hz):
  - pc_en=1, if_id_en=1, pipe_en=1, if_id_flush=id_ex_flush=ex_mem_flush=1 for that cycle.
  - flush_count++.
  - If FETCH_LAT>0: cnt<=FETCH_LAT, go FLUSH; else stay RUN.
- FLUSH:
  - pc_en=if_id_en=pipe_en=1, if_id_flush=1; hz ignored; cnt--.
  - cnt==1 -> RUN.
  - Redirect in FLUSH: handled as in RUN (counter reloaded, flush_count++).
- enable=0 in RUN or FLUSH (evaluated after redirect handling): next state DRAIN, cnt<=DRAIN_CYCLES.
- DRAIN:
  - pc_en=0, if_id_en=1, if_id_flush=1, pipe_en=1; cnt--.
  - mem_redirect in DRAIN: pc_en=1, all three flushes 1 that cycle, so restart fetches the target; flush_count++.
  - cnt==1 -> RUN if enable=1, else IDLE. enable toggling mid-drain never shortens the drain.
- Counters saturate at all-ones; they increment only on the qualifying cycle.
- No combinational path from counters to enables.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding constants (ST_IDLE..ST_DRAIN).
  - Default FETCH_LAT/DRAIN_CYCLES constants.
  - NOP instruction constant 32'h0 used by the IF/ID flush mux.
- One sub-module: sat_counter (CNT_W, inc, clk, rst), instantiated twice for stall_count and flush_count.

Test Plan:
- rst=1 2 cycles, enable=1 -> state=RUN on 1st edge after rst drops; pc_en=if_id_en=pipe_en=1; counters 0.
- RUN, ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. Same with ex_rt=0 -> no stall.
- RUN, mem_redirect=1 one cycle, FETCH_LAT=1 -> cycle N all three flushes=1, pc_en=1; cycle N+1 state=FLUSH, if_id_flush=1; N+2 RUN; flush_count=1.
- mem_redirect=1 and hazard same cycle -> redirect wins: pc_en=1, stall_count unchanged.
- enable 1->0 in RUN -> DRAIN for exactly 4 cycles with pc_en=0, pipe_en=1, then IDLE, busy=0. Re-raise enable at drain cycle 2 -> RUN after the 4th cycle.
- rst=1 during DRAIN cycle 2 -> next cycle IDLE, all outputs 0, counters cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, state encoding and hazard helper.
package cpu_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;

    localparam int DEFAULT_FETCH_LAT    = 1;
    localparam int DEFAULT_DRAIN_CYCLES = 4;
    localparam int DEFAULT_CNT_W        = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A load in EX feeding either source register of the ID instruction; $zero never hazards.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - run/stall/flush/drain sequencer for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int FETCH_LAT    = DEFAULT_FETCH_LAT,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_redirect,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             pipe_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] FETCH_LAT_C    = FETCH_LAT[3:0];
    localparam logic [3:0] DRAIN_CYCLES_C = DRAIN_CYCLES[3:0];
    localparam bit         HAS_FETCH_LAT  = (FETCH_LAT > 0);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hz;
    logic       stall_inc;
    logic       flush_inc;

    assign hz = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        pipe_en      = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_FLUSH: begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                pipe_en  = 1'b1;
                if (state_q == ST_FLUSH) begin
                    if_id_flush = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                // A redirect squashes the ID instruction anyway, so it outranks the stall.
                if (mem_redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_inc    = 1'b1;
                    if (HAS_FETCH_LAT) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FETCH_LAT_C;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if ((state_q == ST_RUN) && hz) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
                if (!enable) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_CYCLES_C;
                end
            end

            ST_DRAIN: begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                pipe_en     = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                // Letting the PC take the target keeps a later restart fetching from the right place.
                if (mem_redirect) begin
                    pc_en        = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_inc    = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign busy  = (state_q != ST_IDLE);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_redirect;
    logic             pc_en, if_id_en, pipe_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [5:0]       ctl;

    int n_vec;
    int n_err;

    pipeline_hazard_ctrl #(
        .FETCH_LAT    (1),
        .DRAIN_CYCLES (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .mem_redirect (mem_redirect),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .pipe_en      (pipe_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .busy         (busy),
        .state        (state),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    // {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush}
    assign ctl = {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazard();
        ex_mem_read = 1'b0;
        ex_rt       = 5'd0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        mem_redirect = 1'b0;
        clear_hazard();
        tick();
        tick();
        n_vec++;
        if (state !== 3'd0 || ctl !== 6'b000000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs state=%0d ctl=%b busy=%b want state=0 ctl=000000 busy=0", state, ctl, busy);
        end
        n_vec++;
        if (stall_count !== 3'd0 || flush_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_counters stall=%0d flush=%0d want 0 0", stall_count, flush_count);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (state !== 3'd1 || ctl !== 6'b111000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_run state=%0d ctl=%b busy=%b want state=1 ctl=111000 busy=1", state, ctl, busy);
        end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        n_vec++;
        if (ctl !== 6'b001010) begin
            n_err++;
            $display("FAIL lu_rs_ctl got %b want 001010", ctl);
        end
        tick();
        clear_hazard();
        #1;
        n_vec++;
        if (stall_count !== 3'd1 || state !== 3'd1 || ctl !== 6'b111000) begin
            n_err++;
            $display("FAIL lu_one_bubble stall=%0d state=%0d ctl=%b want 1 1 111000", stall_count, state, ctl);
        end
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        n_vec++;
        if (ctl !== 6'b111000) begin
            n_err++;
            $display("FAIL lu_zero_reg_ctl got %b want 111000", ctl);
        end
        tick();
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 6'b001010 || stall_count !== 3'd1) begin
            n_err++;
            $display("FAIL lu_rt_ctl ctl=%b stall=%0d want 001010 1", ctl, stall_count);
        end
        tick();
        id_uses_rt = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 6'b111000 || stall_count !== 3'd2) begin
            n_err++;
            $display("FAIL lu_rt_unused ctl=%b stall=%0d want 111000 2", ctl, stall_count);
        end
        tick();
        clear_hazard();
    endtask

    task automatic test_redirect();
        mem_redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 6'b111111) begin
            n_err++;
            $display("FAIL redir_ctl got %b want 111111", ctl);
        end
        tick();
        mem_redirect = 1'b0;
        #1;
        n_vec++;
        if (state !== 3'd2 || ctl !== 6'b111100 || flush_count !== 3'd1) begin
            n_err++;
            $display("FAIL redir_flush state=%0d ctl=%b flush=%0d want 2 111100 1", state, ctl, flush_count);
        end
        tick();
        n_vec++;
        if (state !== 3'd1 || ctl !== 6'b111000) begin
            n_err++;
            $display("FAIL redir_back_run state=%0d ctl=%b want 1 111000", state, ctl);
        end
    endtask

    task automatic test_redirect_priority();
        mem_redirect = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        n_vec++;
        if (ctl !== 6'b111111) begin
            n_err++;
            $display("FAIL prio_ctl got %b want 111111", ctl);
        end
        tick();
        mem_redirect = 1'b0;
        #1;
        n_vec++;
        if (state !== 3'd2 || ctl !== 6'b111100 || stall_count !== 3'd2 || flush_count !== 3'd2) begin
            n_err++;
            $display("FAIL prio_flush_hz_ignored state=%0d ctl=%b stall=%0d flush=%0d want 2 111100 2 2",
                     state, ctl, stall_count, flush_count);
        end
        clear_hazard();
        tick();
        n_vec++;
        if (state !== 3'd1 || stall_count !== 3'd2) begin
            n_err++;
            $display("FAIL prio_after state=%0d stall=%0d want 1 2", state, stall_count);
        end
    endtask

    task automatic test_drain();
        enable = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 6'b111000) begin
            n_err++;
            $display("FAIL drain_req_ctl got %b want 111000", ctl);
        end
        tick();
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (state !== 3'd3 || ctl !== 6'b011100 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL drain_cycle%0d state=%0d ctl=%b busy=%b want 3 011100 1", i, state, ctl, busy);
            end
            tick();
        end
        n_vec++;
        if (state !== 3'd0 || ctl !== 6'b000000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_idle state=%0d ctl=%b busy=%b want 0 000000 0", state, ctl, busy);
        end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        #1;
        n_vec++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL redrain_c2 state=%0d want 3", state);
        end
        tick();
        tick();
        n_vec++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL redrain_c4 state=%0d want 3", state);
        end
        tick();
        n_vec++;
        if (state !== 3'd1 || ctl !== 6'b111000) begin
            n_err++;
            $display("FAIL redrain_run state=%0d ctl=%b want 1 111000", state, ctl);
        end
    endtask

    task automatic test_saturation();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        clear_hazard();
        #1;
        n_vec++;
        if (stall_count !== 3'd7 || state !== 3'd1) begin
            n_err++;
            $display("FAIL stall_saturate stall=%0d state=%0d want 7 1", stall_count, state);
        end
    endtask

    task automatic test_reset_mid_drain();
        enable = 1'b0;
        tick();
        mem_redirect = 1'b1;
        #1;
        n_vec++;
        if (state !== 3'd3 || ctl !== 6'b111111) begin
            n_err++;
            $display("FAIL drain_redir state=%0d ctl=%b want 3 111111", state, ctl);
        end
        tick();
        mem_redirect = 1'b0;
        #1;
        n_vec++;
        if (state !== 3'd3 || flush_count !== 3'd3) begin
            n_err++;
            $display("FAIL drain_redir_count state=%0d flush=%0d want 3 3", state, flush_count);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (state !== 3'd0 || ctl !== 6'b000000 || busy !== 1'b0 ||
            stall_count !== 3'd0 || flush_count !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid_drain state=%0d ctl=%b busy=%b stall=%0d flush=%0d want 0 000000 0 0 0",
                     state, ctl, busy, stall_count, flush_count);
        end
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_priority();
        test_drain();
        test_saturation();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
